// File: rtl/sd_pkt_committer_pkg.sv
// Shared types and helpers for the packet committer: verdict encoding,
// drop counter width and small combinational helpers.
package sd_pkt_committer_pkg;

  typedef enum logic [1:0] {
    V_COMMIT,
    V_ABORT,
    V_ABORT_DROP
  } verdict_t;

  localparam int unsigned DROP_W = 16;

  // Verdict for a packet whose eop word arrives inside the legal length window.
  function automatic verdict_t eop_verdict(input logic err, input logic runt);
    return (err || runt) ? V_ABORT : V_COMMIT;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sd_pkt_committer_if.sv
// Upstream word stream plus downstream commit-FIFO write side of the committer.
// The master modport is the committer's view; slave is its environment's.
interface sd_pkt_committer_if #(
  parameter int width = 8
);
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;
  logic             c_eop;
  logic             c_err;
  logic             p_srdy;
  logic             p_drdy;
  logic [width-1:0] p_data;
  logic             p_commit;
  logic             p_abort;

  modport master (
    input  c_srdy, c_data, c_eop, c_err, p_drdy,
    output c_drdy, p_srdy, p_data, p_commit, p_abort
  );

  modport slave (
    output c_srdy, c_data, c_eop, c_err, p_drdy,
    input  c_drdy, p_srdy, p_data, p_commit, p_abort
  );
endinterface

// File: rtl/sd_pkt_committer_output.sv
// One-entry srdy/drdy output register: accepts a new word whenever it is
// empty or its current word is being taken downstream in the same cycle.
module sd_pkt_committer_output #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ic_srdy,
  output logic             ic_drdy,
  input  logic [width-1:0] ic_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data
);

  assign ic_drdy = p_drdy | ~p_srdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_srdy <= 1'b0;
    end else if (ic_srdy && ic_drdy) begin
      p_srdy <= 1'b1;
    end else if (p_drdy) begin
      p_srdy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ic_srdy && ic_drdy) begin
      p_data <= ic_data;
    end
  end

endmodule

// File: rtl/sd_pkt_committer.sv
// Frames a word stream into a commit-capable FIFO: forwards words, then ends
// each packet with a single commit or abort pulse once the output is drained.
module sd_pkt_committer
  import sd_pkt_committer_pkg::*;
#(
  parameter int width   = 8,
  parameter int min_len = 4,
  parameter int max_len = 1518,
  parameter int lsz     = $clog2(max_len + 1)
) (
  input  logic              clk,
  input  logic              reset,
  sd_pkt_committer_if.master bus,
  output logic [DROP_W-1:0] drop_count
);

  typedef enum logic [1:0] {
    PKT,
    DRAIN,
    DROP
  } state_t;

  localparam logic [lsz-1:0] MIN_LEN = lsz'(min_len);
  localparam logic [lsz-1:0] MAX_LEN = lsz'(max_len);

  state_t         state;
  verdict_t       verdict;
  logic [lsz-1:0] len;
  logic [lsz-1:0] len_next;
  logic           commit_q;
  logic           abort_q;
  logic           out_srdy;
  logic           out_drdy;
  logic           accept;
  logic           out_empty_next;

  assign len_next       = len + 1'b1;
  assign accept         = bus.c_srdy & bus.c_drdy;
  assign out_srdy       = (state == PKT) & bus.c_srdy;
  // Nothing is loaded during DRAIN, so the register is empty next cycle
  // whenever it is empty now or its word is being taken now.
  assign out_empty_next = ~bus.p_srdy | bus.p_drdy;
  assign bus.p_commit   = commit_q;
  assign bus.p_abort    = abort_q;

  always_comb begin
    bus.c_drdy = 1'b0;
    case (state)
      PKT:     bus.c_drdy = out_drdy;
      DROP:    bus.c_drdy = 1'b1;
      default: bus.c_drdy = 1'b0;
    endcase
    if (reset) begin
      bus.c_drdy = 1'b0;
    end
  end

  sd_pkt_committer_output #(
    .width(width)
  ) u_output (
    .clk    (clk),
    .reset  (reset),
    .ic_srdy(out_srdy),
    .ic_drdy(out_drdy),
    .ic_data(bus.c_data),
    .p_srdy (bus.p_srdy),
    .p_drdy (bus.p_drdy),
    .p_data (bus.p_data)
  );

  // The pulse is registered one cycle ahead of the empty output register;
  // DRAIN is held through the pulse cycle so c_drdy stays low there too.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PKT;
      verdict    <= V_COMMIT;
      len        <= '0;
      commit_q   <= 1'b0;
      abort_q    <= 1'b0;
      drop_count <= '0;
    end else begin
      commit_q <= 1'b0;
      abort_q  <= 1'b0;
      case (state)
        PKT: begin
          if (accept) begin
            len <= len_next;
            if (bus.c_eop) begin
              verdict <= eop_verdict(bus.c_err, len_next < MIN_LEN);
              state   <= DRAIN;
            end else if (len_next == MAX_LEN) begin
              verdict <= V_ABORT_DROP;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (commit_q || abort_q) begin
            len   <= '0;
            state <= (verdict == V_ABORT_DROP) ? DROP : PKT;
          end else if (out_empty_next) begin
            if (verdict == V_COMMIT) begin
              commit_q <= 1'b1;
            end else begin
              abort_q    <= 1'b1;
              drop_count <= sat_inc(drop_count);
            end
          end
        end
        DROP: begin
          if (accept && bus.c_eop) begin
            len   <= '0;
            state <= PKT;
          end
        end
        default: begin
          len   <= '0;
          state <= PKT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_pkt_committer.sv
// Randomized self-checking bench for sd_pkt_committer against a packet-level
// model: forwarded words = first min(n,max_len), commit iff legal length and no error.
module tb_sd_pkt_committer;

  localparam int W    = 8;
  localparam int MINL = 4;
  localparam int MAXL = 8;

  typedef struct {
    bit commit;
    int words;
    int cyc;
  } pulse_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] drop_count;

  sd_pkt_committer_if #(.width(W)) bus ();

  sd_pkt_committer #(
    .width  (W),
    .min_len(MINL),
    .max_len(MAXL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle        = 0;
  int last_word_cyc = 0;
  int overlap_viol = 0;
  int exp_drops    = 0;
  bit rand_drdy    = 1'b0;

  logic [W-1:0] tx_q[$];
  logic [W-1:0] obs_words[$];
  logic [W-1:0] exp_words[$];
  pulse_t       obs_pulses[$];
  pulse_t       exp_pulses[$];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.p_srdy && bus.p_drdy) begin
        obs_words.push_back(bus.p_data);
        last_word_cyc = cycle;
      end
      if (bus.p_commit || bus.p_abort) begin
        if (bus.p_srdy || (bus.p_commit && bus.p_abort)) overlap_viol++;
        obs_pulses.push_back('{bus.p_commit, obs_words.size(), cycle});
      end
    end
  end

  initial begin
    bus.p_drdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.p_drdy = rand_drdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  function automatic int word_diffs();
    int no = obs_words.size();
    int ne = exp_words.size();
    int n  = (no > ne) ? no - ne : ne - no;
    for (int i = 0; i < ((no < ne) ? no : ne); i++)
      if (obs_words[i] !== exp_words[i]) n++;
    return n;
  endfunction

  function automatic int pulse_diffs();
    int no = obs_pulses.size();
    int ne = exp_pulses.size();
    int n  = (no > ne) ? no - ne : ne - no;
    for (int i = 0; i < ((no < ne) ? no : ne); i++)
      if (obs_pulses[i].commit != exp_pulses[i].commit || obs_pulses[i].words != exp_pulses[i].words) n++;
    return n;
  endfunction

  task automatic clear_logs();
    obs_words.delete();
    exp_words.delete();
    obs_pulses.delete();
    exp_pulses.delete();
    overlap_viol = 0;
  endtask

  // Drives tx_q as one burst; starts and ends just after a rising edge.
  task automatic send_words(input bit last_eop, input bit err, output bit ok);
    int n = tx_q.size();
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      int budget = 0;
      bus.c_srdy = 1'b1;
      bus.c_data = tx_q[i];
      bus.c_eop  = last_eop && (i == n - 1);
      bus.c_err  = bus.c_eop ? err : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      while (!bus.c_drdy && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.c_drdy) begin
        ok = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.c_srdy = 1'b0;
    bus.c_eop  = 1'b0;
    bus.c_err  = 1'b0;
  endtask

  task automatic send_pkt(input int n, input bit err, output bit ok);
    int  nf = (n > MAXL) ? MAXL : n;
    bit  good = (n >= MINL) && (n <= MAXL) && !err;
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(W'($urandom));
    for (int i = 0; i < nf; i++) exp_words.push_back(tx_q[i]);
    exp_pulses.push_back('{good, exp_words.size(), 0});
    if (!good && exp_drops < 65535) exp_drops++;
    send_words(1'b1, err, ok);
  endtask

  task automatic wait_pulses(output bit ok);
    int k = 0;
    while (obs_pulses.size() < exp_pulses.size() && k < 2000) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_pulses.size() >= exp_pulses.size());
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.c_srdy = 1'b0;
    bus.c_data = '0;
    bus.c_eop  = 1'b0;
    bus.c_err  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (bus.p_srdy !== 1'b0) begin tests_failed++; $display("FAIL reset_p_srdy: got %b want 0", bus.p_srdy); end
    tests_run++; if ({bus.p_commit, bus.p_abort} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses: got %b want 00", {bus.p_commit, bus.p_abort}); end
    tests_run++; if (bus.c_drdy !== 1'b0) begin tests_failed++; $display("FAIL reset_c_drdy: got %b want 0", bus.c_drdy); end
    tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.c_drdy !== 1'b1) begin tests_failed++; $display("FAIL post_reset_c_drdy: got %b want 1", bus.c_drdy); end
    exp_drops = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_good6();
    bit ok, done;
    logic [2:0] dr, pl;
    int lat;
    clear_logs();
    rand_drdy = 1'b0;
    send_pkt(6, 1'b0, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dr[2-i] = bus.c_drdy;
      pl[2-i] = bus.p_commit;
    end
    wait_pulses(done);
    lat = (obs_pulses.size() > 0) ? obs_pulses[0].cyc - last_word_cyc : -1;
    tests_run++; if (!(ok && done)) begin tests_failed++; $display("FAIL good6_done: got send=%0d pulse=%0d want 1 1", ok, done); end
    tests_run++; if (dr !== 3'b001) begin tests_failed++; $display("FAIL good6_gap_c_drdy: got %b want 001", dr); end
    tests_run++; if (pl !== 3'b010) begin tests_failed++; $display("FAIL good6_commit_timing: got %b want 010", pl); end
    tests_run++; if (word_diffs() !== 0) begin tests_failed++; $display("FAIL good6_words: got %0d diffs want 0", word_diffs()); end
    tests_run++; if (pulse_diffs() !== 0) begin tests_failed++; $display("FAIL good6_pulses: got %0d diffs want 0", pulse_diffs()); end
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL good6_latency: got %0d want 1", lat); end
    tests_run++; if (drop_count !== 16'(exp_drops)) begin tests_failed++; $display("FAIL good6_drop_count: got %0d want %0d", drop_count, exp_drops); end
  endtask

  task automatic test_err6();
    bit ok, done;
    clear_logs();
    send_pkt(6, 1'b1, ok);
    wait_pulses(done);
    tests_run++; if (!(ok && done)) begin tests_failed++; $display("FAIL err6_done: got send=%0d pulse=%0d want 1 1", ok, done); end
    tests_run++; if (word_diffs() !== 0) begin tests_failed++; $display("FAIL err6_words: got %0d diffs want 0", word_diffs()); end
    tests_run++; if (pulse_diffs() !== 0) begin tests_failed++; $display("FAIL err6_pulses: got %0d diffs want 0", pulse_diffs()); end
    tests_run++; if (drop_count !== 16'd1) begin tests_failed++; $display("FAIL err6_drop_count: got %0d want 1", drop_count); end
  endtask

  task automatic test_runt();
    bit ok, a, b, c, done;
    clear_logs();
    send_pkt(3, 1'b0, a);
    send_pkt(4, 1'b0, b);
    send_pkt(1, 1'b0, c);
    ok = a && b && c;
    wait_pulses(done);
    tests_run++; if (!(ok && done)) begin tests_failed++; $display("FAIL runt_done: got send=%0d pulse=%0d want 1 1", ok, done); end
    tests_run++; if (word_diffs() !== 0) begin tests_failed++; $display("FAIL runt_words: got %0d diffs want 0", word_diffs()); end
    tests_run++; if (pulse_diffs() !== 0) begin tests_failed++; $display("FAIL runt_pulses: got %0d diffs want 0", pulse_diffs()); end
    tests_run++; if (drop_count !== 16'(exp_drops)) begin tests_failed++; $display("FAIL runt_drop_count: got %0d want %0d", drop_count, exp_drops); end
  endtask

  task automatic test_oversize();
    bit a, b, c, d, done;
    clear_logs();
    send_pkt(12, 1'b0, a);
    send_pkt(5, 1'b0, b);
    send_pkt(MAXL, 1'b0, c);
    send_pkt(MAXL + 1, 1'b0, d);
    wait_pulses(done);
    tests_run++; if (!(a && b && c && d && done)) begin tests_failed++; $display("FAIL oversize_done: got %b want 11111", {a, b, c, d, done}); end
    tests_run++; if (word_diffs() !== 0) begin tests_failed++; $display("FAIL oversize_words: got %0d diffs want 0", word_diffs()); end
    tests_run++; if (pulse_diffs() !== 0) begin tests_failed++; $display("FAIL oversize_pulses: got %0d diffs want 0", pulse_diffs()); end
    tests_run++; if (drop_count !== 16'(exp_drops)) begin tests_failed++; $display("FAIL oversize_drop_count: got %0d want %0d", drop_count, exp_drops); end
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok, done;
    int commits;
    clear_logs();
    all_ok = 1'b1;
    rand_drdy = 1'b1;
    for (int p = 0; p < 20; p++) begin
      send_pkt(5, 1'b0, ok);
      all_ok &= ok;
    end
    wait_pulses(done);
    rand_drdy = 1'b0;
    commits = 0;
    foreach (obs_pulses[i]) if (obs_pulses[i].commit) commits++;
    tests_run++; if (!(all_ok && done)) begin tests_failed++; $display("FAIL b2b_done: got send=%0d pulse=%0d want 1 1", all_ok, done); end
    tests_run++; if (obs_words.size() !== 100) begin tests_failed++; $display("FAIL b2b_word_count: got %0d want 100", obs_words.size()); end
    tests_run++; if (word_diffs() !== 0) begin tests_failed++; $display("FAIL b2b_words: got %0d diffs want 0", word_diffs()); end
    tests_run++; if (commits !== 20) begin tests_failed++; $display("FAIL b2b_commits: got %0d want 20", commits); end
    tests_run++; if (pulse_diffs() !== 0) begin tests_failed++; $display("FAIL b2b_pulse_order: got %0d diffs want 0", pulse_diffs()); end
    tests_run++; if (overlap_viol !== 0) begin tests_failed++; $display("FAIL b2b_pulse_overlap: got %0d want 0", overlap_viol); end
  endtask

  task automatic test_random_mix();
    bit ok, all_ok, done;
    clear_logs();
    all_ok = 1'b1;
    rand_drdy = 1'b1;
    for (int p = 0; p < 30; p++) begin
      send_pkt($urandom_range(1, 12), ($urandom_range(0, 3) == 0), ok);
      all_ok &= ok;
    end
    wait_pulses(done);
    rand_drdy = 1'b0;
    tests_run++; if (!(all_ok && done)) begin tests_failed++; $display("FAIL mix_done: got send=%0d pulse=%0d want 1 1", all_ok, done); end
    tests_run++; if (word_diffs() !== 0) begin tests_failed++; $display("FAIL mix_words: got %0d diffs want 0", word_diffs()); end
    tests_run++; if (pulse_diffs() !== 0) begin tests_failed++; $display("FAIL mix_pulses: got %0d diffs want 0", pulse_diffs()); end
    tests_run++; if (overlap_viol !== 0) begin tests_failed++; $display("FAIL mix_pulse_overlap: got %0d want 0", overlap_viol); end
    tests_run++; if (drop_count !== 16'(exp_drops)) begin tests_failed++; $display("FAIL mix_drop_count: got %0d want %0d", drop_count, exp_drops); end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2, done;
    clear_logs();
    tx_q.delete();
    for (int i = 0; i < 3; i++) tx_q.push_back(W'($urandom));
    send_words(1'b0, 1'b0, ok);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++; if (bus.p_srdy !== 1'b0) begin tests_failed++; $display("FAIL midreset_p_srdy: got %b want 0", bus.p_srdy); end
    tests_run++; if ({bus.p_commit, bus.p_abort} !== 2'b00) begin tests_failed++; $display("FAIL midreset_pulses: got %b want 00", {bus.p_commit, bus.p_abort}); end
    tests_run++; if (drop_count !== 16'd0) begin tests_failed++; $display("FAIL midreset_drop_count: got %0d want 0", drop_count); end
    @(posedge clk);
    #1 reset = 1'b0;
    exp_drops = 0;
    clear_logs();
    send_pkt(5, 1'b0, ok2);
    wait_pulses(done);
    tests_run++; if (!(ok && ok2 && done)) begin tests_failed++; $display("FAIL midreset_done: got %b want 111", {ok, ok2, done}); end
    tests_run++; if (word_diffs() !== 0) begin tests_failed++; $display("FAIL midreset_words: got %0d diffs want 0", word_diffs()); end
    tests_run++; if (pulse_diffs() !== 0) begin tests_failed++; $display("FAIL midreset_pulses_after: got %0d diffs want 0", pulse_diffs()); end
  endtask

  initial begin
    test_reset();
    test_good6();
    test_err6();
    test_runt();
    test_oversize();
    test_back_to_back();
    test_random_mix();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
